// File: rtl/hslp_mac_acc_pkg.sv
// Shared types and constants for the HSLP dot-product accumulator.
// Holds the FSM encoding, the product width and the beat-counter increment helper.
package hslp_mac_acc_pkg;

   localparam int PROD_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Beat counter sticks at its maximum instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/hslp_sat_add.sv
// ACC_W-bit accumulator adder for one 16-bit product, with saturate-or-wrap
// behaviour on overflow and an overflow flag.
module hslp_sat_add
   import hslp_mac_acc_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int SAT   = 1
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] op_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              ovf_o
);

   logic [ACC_W:0] wide;

   // The extra top bit is the carry out of the ACC_W-bit add.
   always_comb begin
      wide  = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, op_i};
      ovf_o = wide[ACC_W];
      if ((SAT != 0) && wide[ACC_W]) sum_o = '1;
      else                           sum_o = wide[ACC_W-1:0];
   end

endmodule

// File: rtl/hslp_mac_acc.sv
// Frame accumulator for HSLP approximate-multiplier products: sums beats until
// in_last, then holds the frame result until the consumer takes it.
module hslp_mac_acc
   import hslp_mac_acc_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int SAT   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [ACC_W-1:0]  add_sum;
   logic              add_ovf;

   hslp_sat_add #(
      .ACC_W (ACC_W),
      .SAT   (SAT)
   ) u_add (
      .acc_i (acc_q),
      .op_i  (in_prod),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_ACC: begin
            if (in_valid) begin
               acc_d = add_sum;
               cnt_d = cnt_inc(cnt_q);
               ovf_d = ovf_q | add_ovf;
               if (in_last) state_d = ST_HOLD;
            end
         end
         // Release clears the frame; HOLD has no input path, so nothing is
         // accepted in the release cycle itself.
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_ACC;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_HOLD);
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hslp_mac_acc.sv
// Bench for hslp_mac_acc: four configurations (24/16 bit, saturate/wrap) share
// one stimulus stream; frame results are checked through a scoreboard queue.
module tb_hslp_mac_acc;

   typedef struct {
      logic [31:0] sum [4];
      logic [3:0]  ovf;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct {
      int          n;
      int unsigned v [4];
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_prod = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic [3:0]  in_rdy, o_vld, o_ovf;
   logic [7:0]  o_cnt [4];
   logic [23:0] s24s, s24w;
   logic [15:0] s16s, s16w;
   logic [31:0] sums [4];

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q [$];
   vec_t tbl [$];

   always #5 clk = ~clk;

   hslp_mac_acc #(.ACC_W(24), .SAT(1)) u_24s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
      .in_prod(in_prod), .in_last(in_last), .out_valid(o_vld[0]),
      .out_ready(out_ready), .out_sum(s24s), .out_count(o_cnt[0]), .out_ovf(o_ovf[0]));
   hslp_mac_acc #(.ACC_W(24), .SAT(0)) u_24w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
      .in_prod(in_prod), .in_last(in_last), .out_valid(o_vld[1]),
      .out_ready(out_ready), .out_sum(s24w), .out_count(o_cnt[1]), .out_ovf(o_ovf[1]));
   hslp_mac_acc #(.ACC_W(16), .SAT(1)) u_16s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
      .in_prod(in_prod), .in_last(in_last), .out_valid(o_vld[2]),
      .out_ready(out_ready), .out_sum(s16s), .out_count(o_cnt[2]), .out_ovf(o_ovf[2]));
   hslp_mac_acc #(.ACC_W(16), .SAT(0)) u_16w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[3]),
      .in_prod(in_prod), .in_last(in_last), .out_valid(o_vld[3]),
      .out_ready(out_ready), .out_sum(s16w), .out_count(o_cnt[3]), .out_ovf(o_ovf[3]));

   assign sums[0] = {8'd0, s24s};
   assign sums[1] = {8'd0, s24w};
   assign sums[2] = {16'd0, s16s};
   assign sums[3] = {16'd0, s16w};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t mk_exp(input int c, input int unsigned a, input int unsigned b,
                                   input int unsigned d, input int unsigned e, input logic [3:0] o);
      exp_t x;
      x.cnt    = 8'(c);
      x.sum[0] = a;
      x.sum[1] = b;
      x.sum[2] = d;
      x.sum[3] = e;
      x.ovf    = o;
      return x;
   endfunction

   task automatic add_vec(input int n, input int unsigned v0, input int unsigned v1,
                          input int unsigned v2, input int unsigned v3, input exp_t e);
      vec_t r;
      r.n = n;
      r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
      r.e = e;
      tbl.push_back(r);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic send_beat(input int unsigned v, input logic last);
      int w = 0;
      in_valid = 1'b1;
      in_prod  = 16'(v);
      in_last  = last;
      while (in_rdy !== 4'hF) begin
         @(posedge clk); #1;
         w++;
         if (w > 20) begin
            chk("in_ready_timeout", {28'd0, in_rdy}, 32'hF);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (last) chk("latency_out_valid", {28'd0, o_vld}, 32'hF);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard: each released result is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (|o_vld) && out_ready) begin
         chk("out_valid_agree", {28'd0, o_vld}, 32'hF);
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("out_sum[%0d]", k), sums[k], e.sum[k]);
               chk($sformatf("out_count[%0d]", k), {24'd0, o_cnt[k]}, {24'd0, e.cnt});
               chk($sformatf("out_ovf[%0d]", k), {31'd0, o_ovf[k]}, {31'd0, e.ovf[k]});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // order of sums/ovf bits: 24-sat, 24-wrap, 16-sat, 16-wrap
      add_vec(3, 100, 200, 300, 0, mk_exp(3, 600, 600, 600, 600, 4'b0000));
      add_vec(1, 65025, 0, 0, 0, mk_exp(1, 65025, 65025, 65025, 65025, 4'b0000));
      add_vec(2, 60000, 10000, 0, 0, mk_exp(2, 70000, 70000, 65535, 4464, 4'b1100));
      add_vec(4, 65535, 65535, 65535, 65535, mk_exp(4, 262140, 262140, 65535, 65532, 4'b1100));
      add_vec(1, 0, 0, 0, 0, mk_exp(1, 0, 0, 0, 0, 4'b0000));
      add_vec(2, 1, 65535, 0, 0, mk_exp(2, 65536, 65536, 65535, 0, 4'b1100));

      idle(2);
      chk("rst_in_ready", {28'd0, in_rdy}, 32'hF);
      chk("rst_out_valid", {28'd0, o_vld}, 32'h0);
      chk("rst_out_ovf", {28'd0, o_ovf}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_out_sum[%0d]", k), sums[k], 32'd0);
         chk($sformatf("rst_out_count[%0d]", k), {24'd0, o_cnt[k]}, 32'd0);
      end
      rst_n = 1'b1;
      idle(1);

      foreach (tbl[i]) begin
         for (int b = 0; b < tbl[i].n; b++) begin
            if (b == tbl[i].n - 1) exp_q.push_back(tbl[i].e);
            send_beat(tbl[i].v[b], b == tbl[i].n - 1);
         end
      end
      idle(2);
      chk("back_to_acc", {28'd0, in_rdy}, 32'hF);

      // 300 beats of 1 with a bubble every third cycle
      for (int b = 0; b < 300; b++) begin
         if (b % 2 == 1) idle(1);
         if (b == 299) exp_q.push_back(mk_exp(255, 300, 300, 300, 300, 4'b0000));
         send_beat(1, b == 299);
      end
      // running sum visible during ACC
      send_beat(40, 1'b0);
      send_beat(2, 1'b0);
      chk("running_sum", sums[0], 32'd42);
      exp_q.push_back(mk_exp(3, 42, 42, 42, 42, 4'b0000));
      send_beat(0, 1'b1);

      // 24-bit overflow: 260 x 65535
      for (int b = 0; b < 260; b++) begin
         if (b == 259) exp_q.push_back(mk_exp(255, 32'hFFFFFF, 261884, 65535, 65276, 4'b1111));
         send_beat(65535, b == 259);
      end
      idle(2);

      // held result with in_valid asserted through HOLD and the release cycle
      out_ready = 1'b0;
      exp_q.push_back(mk_exp(1, 65025, 65025, 65025, 65025, 4'b0000));
      send_beat(65025, 1'b1);
      in_valid = 1'b1;
      in_prod  = 16'd999;
      for (int c = 0; c < 5; c++) begin
         chk("hold_in_ready", {28'd0, in_rdy}, 32'h0);
         chk("hold_out_valid", {28'd0, o_vld}, 32'hF);
         chk("hold_sum", sums[0], 32'd65025);
         chk("hold_count", {24'd0, o_cnt[3]}, 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", {28'd0, in_rdy}, 32'hF);
      chk("release_no_bypass_sum", sums[1], 32'd0);
      chk("release_no_bypass_cnt", {24'd0, o_cnt[0]}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_release_accept", sums[2], 32'd999);
      exp_q.push_back(mk_exp(2, 1000, 1000, 1000, 1000, 4'b0000));
      send_beat(1, 1'b1);
      idle(2);

      // reset mid-frame discards the partial sum
      send_beat(11, 1'b0);
      send_beat(22, 1'b0);
      rst_n = 1'b0;
      idle(1);
      chk("midframe_rst_sum", sums[0], 32'd0);
      chk("midframe_rst_cnt", {24'd0, o_cnt[0]}, 32'd0);
      rst_n = 1'b1;
      send_beat(5, 1'b0);
      exp_q.push_back(mk_exp(2, 12, 12, 12, 12, 4'b0000));
      send_beat(7, 1'b1);
      idle(2);

      // reset in HOLD drops the pending result
      out_ready = 1'b0;
      send_beat(500, 1'b1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("hold_rst_out_valid", {28'd0, o_vld}, 32'h0);
      chk("hold_rst_sum", sums[3], 32'd0);
      idle(3);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hslp_mac_acc.md
HSLP_MAC_ACC -- requirements
Module: hslp_mac_acc

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits, legal range 16..32.
REQ-002 Parameter SAT, default 1: 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_prod/in_last carry a valid product beat.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_prod  input  16  unsigned 16-bit product from the 8x8 HSLP approximate multiplier.
REQ-008 in_last  input  1  beat closes the current dot-product frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_sum  output  ACC_W  accumulated frame sum.
REQ-012 out_count  output  8  beats in the frame, saturating at 255.
REQ-013 out_ovf  output  1  sticky: accumulator overflowed at least once in the frame.

Function
REQ-014 The FSM SHALL have two states: ACC (collecting beats) and HOLD (presenting a result).
REQ-015 In ACC, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-016 A beat SHALL be accepted only when in_valid and in_ready are both 1.
REQ-017 On an accepted beat, acc SHALL be updated to acc + zero-extended in_prod.
REQ-018 On the same beat, cnt SHALL increment, saturating at 255.
REQ-019 On an accepted beat whose sum exceeds 2^ACC_W-1: SAT=1 SHALL load all-ones, SAT=0 SHALL keep the low ACC_W bits; both SHALL set ovf.
REQ-020 An accepted beat with in_last=1 SHALL move ACC->HOLD; out_sum/out_count/out_ovf SHALL show that beat's updated values in the next cycle (latency 1).
REQ-021 In HOLD, out_sum, out_count and out_ovf SHALL stay stable until out_ready=1.
REQ-022 In HOLD with out_ready=1, the block SHALL clear acc, cnt and ovf and return to ACC in the next cycle.
REQ-023 No beat SHALL be accepted in the cycle the result is released (no bypass); the earliest next acceptance is the following cycle.
REQ-024 A frame of one beat (in_last on the first beat) SHALL be legal; out_count SHALL be 1.
REQ-025 in_valid=0 in ACC SHALL leave all state unchanged; bubbles within a frame are permitted.
REQ-026 In ACC, out_sum SHALL show the running acc; only out_valid qualifies it.

Reset
REQ-027 When rst_n=0 at a clock edge: state=ACC, acc=0, cnt=0, ovf=0, so in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-028 Reset mid-frame or in HOLD SHALL discard partial or pending results without emitting them.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (ACC=0, HOLD=1) and the product width constant PROD_W=16.
REQ-030 One sub-module is natural: hslp_sat_add (ACC_W-bit add of the 16-bit operand with the SAT/wrap and overflow flag); the FSM and registers stay in the top.
REQ-031 The block SHALL contain no multiplier; products come from HSLP_1124 instances upstream.

Verification
REQ-032 Reset, then beats 100, 200, 300 (last on 300), out_ready=1 -> out_valid one cycle after the last beat, out_sum=600, out_count=3, out_ovf=0; back to ACC the next cycle.
REQ-033 Single beat 65025 with in_last, out_ready held 0 for 5 cycles -> out_sum=65025 and out_count=1 stable, in_ready=0 throughout, release on the 6th cycle.
REQ-034 ACC_W=16, SAT=1: beats 60000, 10000 (last) -> out_sum=65535, out_ovf=1; with SAT=0 -> out_sum=4464, out_ovf=1.
REQ-035 300 beats of value 1 with in_valid bubbles every 3rd cycle -> out_sum=300, out_count=255.
REQ-036 rst_n=0 after 2 beats of a frame, then a new frame 5, 7 (last) -> out_sum=12, out_count=2.
REQ-037 in_valid=1 held during HOLD and the release cycle -> no beat accepted until the cycle after release.
